// File: rtl/bayer_gray.sv
`default_nettype none
// ============================================================================
// Module   : bayer_gray
// Brief    : 2x2 Bayer quad average to half-resolution 12-bit grayscale stream.
// Revision : 1.0
// ============================================================================
module bayer_gray #(
   parameter int IMG_WIDTH  = 1280,
   parameter int IMG_HEIGHT = 960,
   parameter int DATA_W     = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] pix_in,
   input  logic              pix_valid,
   input  logic              sof,
   output logic [DATA_W-1:0] gray_out,
   output logic              gray_valid,
   output logic              gray_eol,
   output logic              gray_eof
);

   localparam int c_XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int c_YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [c_XW-1:0] c_XMAX = c_XW'(IMG_WIDTH - 1);
   localparam logic [c_YW-1:0] c_YMAX = c_YW'(IMG_HEIGHT - 1);
   localparam int c_SW = DATA_W + 2;

   logic [c_XW-1:0]   r_x, w_x, w_x_nxt;
   logic [c_YW-1:0]   r_y, w_y, w_y_nxt;
   logic              w_last_col, w_wr, w_rd, w_quad;
   logic [DATA_W-1:0] r_mem [0:IMG_WIDTH-1];
   logic [DATA_W-1:0] r_rd, r_bl, r_tl, r_br;
   logic              r_s1_v, r_s1_eol, r_s1_eof;
   logic [c_SW-1:0]   w_sum;

   // A qualified sof forces the current beat to raw coordinate (0,0).
   always_comb begin
      w_x        = (sof) ? '0 : r_x;
      w_y        = (sof) ? '0 : r_y;
      w_last_col = (w_x == c_XMAX);
      w_x_nxt    = w_last_col ? '0 : w_x + c_XW'(1);
      w_y_nxt    = w_y;
      if (w_last_col)
         w_y_nxt = (w_y == c_YMAX) ? '0 : w_y + c_YW'(1);
      w_wr   = pix_valid & ~w_y[0];
      w_rd   = pix_valid &  w_y[0];
      w_quad = w_rd & w_x[0];
      w_sum  = c_SW'(r_tl) + c_SW'(r_rd) + c_SW'(r_bl) + c_SW'(r_br);
   end

   // Even x on an odd row prefetches top-left into r_rd; odd x then moves it
   // to r_tl while the same port fetches top-right for the adder stage.
   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[w_x] <= pix_in;
      if (w_rd)
         r_rd <= r_mem[w_x];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x        <= '0;
         r_y        <= '0;
         r_bl       <= '0;
         r_tl       <= '0;
         r_br       <= '0;
         r_s1_v     <= 1'b0;
         r_s1_eol   <= 1'b0;
         r_s1_eof   <= 1'b0;
         gray_out   <= '0;
         gray_valid <= 1'b0;
         gray_eol   <= 1'b0;
         gray_eof   <= 1'b0;
      end else begin
         if (pix_valid) begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
         end
         if (w_rd && !w_x[0])
            r_bl <= pix_in;
         if (w_quad) begin
            r_tl     <= r_rd;
            r_br     <= pix_in;
            r_s1_eol <= w_last_col;
            r_s1_eof <= w_last_col && (w_y == c_YMAX);
         end
         r_s1_v     <= w_quad;
         gray_valid <= r_s1_v;
         gray_eol   <= r_s1_v & r_s1_eol;
         gray_eof   <= r_s1_v & r_s1_eof;
         if (r_s1_v)
            gray_out <= DATA_W'(w_sum >> 2);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bayer_gray.sv
`default_nettype none
// ============================================================================
// Module   : tb_bayer_gray
// Brief    : Scoreboard bench for bayer_gray against a raster-array model.
// Revision : 1.0
// ============================================================================
module tb_bayer_gray;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] pix_in = '0;
   logic          pix_valid = 1'b0;
   logic          sof = 1'b0;
   logic [DW-1:0] gray_out;
   logic          gray_valid, gray_eol, gray_eof;

   bayer_gray #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
      .sof(sof), .gray_out(gray_out), .gray_valid(gray_valid),
      .gray_eol(gray_eol), .gray_eof(gray_eof)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] d;
      logic          eol;
      logic          eof;
      int            c;
   } exp_t;

   exp_t          q[$];
   int            checks = 0;
   int            errors = 0;
   int            img[H][W];
   int            mx = 0, my = 0;
   logic [DW-1:0] last_out = '0;

   // Reference: keep the raw frame as a 2-D array and average each finished quad.
   function automatic void model(input int p, input logic s);
      exp_t e;
      if (s) begin
         mx = 0;
         my = 0;
      end
      img[my][mx] = p;
      if ((my % 2 == 1) && (mx % 2 == 1)) begin
         e.d   = DW'((img[my-1][mx-1] + img[my-1][mx] + img[my][mx-1] + img[my][mx]) / 4);
         e.eol = (mx == W - 1);
         e.eof = (mx == W - 1) && (my == H - 1);
         e.c   = cyc + 1;
         q.push_back(e);
      end
      if (mx == W - 1) begin
         mx = 0;
         my = (my == H - 1) ? 0 : my + 1;
      end else begin
         mx = mx + 1;
      end
   endfunction

   task automatic beat(input int p, input logic s, input logic v);
      pix_in    = DW'(p);
      sof       = s;
      pix_valid = v;
      @(posedge clk);
      #1;
      if (v) model(p, s);
      pix_valid = 1'b0;
      sof       = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      q.delete();
      mx = 0;
      my = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic frame(input int v, input logic with_sof, input int gap_pct);
      int n;
      n = 0;
      while (n < W * H) begin
         if ($urandom_range(0, 99) < gap_pct) begin
            beat($urandom_range(0, 4095), 1'($urandom_range(0, 1)), 1'b0);
         end else begin
            beat((v < 0) ? $urandom_range(0, 4095) : v, with_sof && (n == 0), 1'b1);
            n++;
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         checks++;
         if (gray_valid !== 1'b0 || gray_out !== '0 || gray_eol !== 1'b0 || gray_eof !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b out=%0d eol=%b eof=%b, want all 0",
                     gray_valid, gray_out, gray_eol, gray_eof);
         end
         last_out = '0;
      end else if (gray_valid === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got out=%0d at cycle %0d, want no output", gray_out, cyc);
         end else begin
            e = q.pop_front();
            if (gray_out !== e.d || gray_eol !== e.eol || gray_eof !== e.eof || cyc != e.c) begin
               errors++;
               $display("FAIL gray_pixel: got out=%0d eol=%b eof=%b cyc=%0d, want out=%0d eol=%b eof=%b cyc=%0d",
                        gray_out, gray_eol, gray_eof, cyc, e.d, e.eol, e.eof, e.c);
            end
         end
         last_out = gray_out;
      end else begin
         checks++;
         if (gray_out !== last_out || gray_eol !== 1'b0 || gray_eof !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got out=%0d eol=%b eof=%b, want out=%0d eol=0 eof=0",
                     gray_out, gray_eol, gray_eof, last_out);
         end
         if (q.size() > 0 && q[0].c < cyc) begin
            errors++;
            $display("FAIL missing_output: got none by cycle %0d, want out=%0d at cycle %0d",
                     cyc, q[0].d, q[0].c);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      int row_a[8];
      row_a = '{4095, 4095, 0, 8, 4095, 4095, 12, 16};
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      beat(0, 1'b0, 1'b0);

      // Uniform frame at full rate
      frame(100, 1'b1, 0);
      repeat (3) beat(0, 1'b0, 1'b0);

      // Quad arithmetic, including the full-scale quad
      for (int i = 0; i < 8; i++) beat(row_a[i], i == 0, 1'b1);
      for (int i = 0; i < 8; i++) beat($urandom_range(0, 4095), 1'b0, 1'b1);
      repeat (2) beat(0, 1'b0, 1'b0);

      // Alternating gaps
      for (int i = 0; i < W * H; i++) begin
         beat(100, i == 0, 1'b1);
         beat(0, 1'b0, 1'b0);
      end
      repeat (2) beat(0, 1'b0, 1'b0);

      // Resync: sof arrives on the row-1 x=2 beat
      for (int i = 0; i < 6; i++) beat(30, i == 0, 1'b1);
      frame(50, 1'b1, 0);
      repeat (3) beat(0, 1'b0, 1'b0);

      // Reset right after an odd-row/odd-x beat drops the pending pixel
      for (int i = 0; i < 6; i++) beat(700 + i, i == 0, 1'b1);
      do_reset();
      frame(-1, 1'b1, 0);
      repeat (3) beat(0, 1'b0, 1'b0);

      // Two frames, sof only on the first
      frame(77, 1'b1, 0);
      frame(200, 1'b0, 0);
      repeat (3) beat(0, 1'b0, 1'b0);

      // Reset then a stream with no sof counts from (0,0)
      do_reset();
      frame(-1, 1'b0, 20);

      // Random frames with random gaps and ignored unqualified sof
      for (int f = 0; f < 20; f++) frame(-1, 1'b1, 30);

      repeat (6) beat(0, 1'b0, 1'b0);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d outputs still pending, want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no end of stimulus by %0t, want completion", $time);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/bayer_gray.md
Name: bayer_gray

Overview:
- Upstream feeder for the Sobel convolution stage.
- Converts the raw 12-bit Bayer pixel stream from the CCD capture path into a 12-bit grayscale stream at half resolution in each dimension.
- Each 2x2 Bayer quad (R, G1, G2, B) becomes one gray pixel, gray = (R+G1+G2+B)/4.
- Output `gray_out`/`gray_valid` drives the convolution stage's `pixel_in`/`iDVAL` directly.

Parameters:
- IMG_WIDTH, 1280, raw pixels per line; must be even and >= 4.
- IMG_HEIGHT, 960, raw lines per frame; must be even and >= 2.
- DATA_W, 12, pixel width for both input and output.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- pix_in  input  DATA_W  raw Bayer pixel, raster order.
- pix_valid  input  1  pix_in valid this cycle; arbitrary gaps allowed.
- sof  input  1  start of frame; qualified by pix_valid; marks the beat carrying raw pixel (0,0).
- gray_out  output  DATA_W  grayscale pixel.
- gray_valid  output  1  gray_out valid, single-cycle strobe per output pixel.
- gray_eol  output  1  high with gray_valid on the last gray pixel of an output line.
- gray_eof  output  1  high with gray_valid on the last gray pixel of the frame.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - Reset clears gray_out=0, gray_valid=0, gray_eol=0, gray_eof=0, column counter x=0, row counter y=0 and all pipeline valids.
  - Line buffer contents are not reset and are don't-care.
- Counters:
  - x (0..IMG_WIDTH-1) and y (0..IMG_HEIGHT-1) advance only on accepted beats (pix_valid=1).
  - x wraps IMG_WIDTH-1 -> 0 and increments y; y wraps IMG_HEIGHT-1 -> 0.
  - The current beat's coordinate is (x,y) before the increment.
- sof:
  - A beat with pix_valid=1 and sof=1 is treated as (0,0), regardless of counter state; counters then become x=1, y=0.
  - sof without pix_valid is ignored.
  - Any partially collected quad is discarded. Outputs already in the pipeline still emerge normally.
- Even rows (y[0]=0): each pixel is written to a single-port-per-side line buffer (IMG_WIDTH x DATA_W, inferred RAM) at address x. No output is produced.
- Odd rows (y[0]=1):
  - Even x: hold the bottom-left pixel in a register.
  - Odd x: form the quad from buffer[x-1] (top-left), buffer[x] (top-right), the held bottom-left, and pix_in (bottom-right).
  - RAM reads are issued early enough that the buffer values are available in time; the buffer has one-cycle synchronous read.
  - The buffer is not written on odd rows.
- Arithmetic: sum width is DATA_W+2 (14 bits), unsigned, no saturation. gray_out = sum[DATA_W+1:2], i.e. truncating divide by 4.
- Latency:
  - gray_valid asserts exactly 2 clk cycles after the accepted odd-row/odd-x beat. This holds regardless of pix_valid gaps that follow; the pipeline never stalls.
  - gray_out holds its value until the next gray_valid.
- Rate: IMG_WIDTH/2 outputs per odd raw row, IMG_WIDTH*IMG_HEIGHT/4 per frame.
- gray_eol asserts for the quad at x=IMG_WIDTH-1.
- gray_eof asserts for the quad at x=IMG_WIDTH-1, y=IMG_HEIGHT-1.
- Back-to-back pix_valid at full rate must be sustained, with no output lost or duplicated.
- Reset mid-frame: outputs drop immediately (asynchronous). The next stream must begin with sof; beats without sof after reset are counted from (0,0).

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=4 unless noted):
1. Uniform frame:
   - Stimulus: sof, then 16 beats of 12'd100 at full rate.
   - Required: exactly 4 gray_valid pulses, all gray_out=100. gray_eol on the 2nd and 4th pulse; gray_eof on the 4th only. Each pulse 2 cycles after raw beats 5, 7, 13 and 15 (0-based).
2. Quad arithmetic:
   - Stimulus: row0 = 4095,4095,0,8; row1 = 4095,4095,12,16.
   - Required: first output 4095 (sum 16380, no overflow); second output 9 (36/4).
3. Gaps:
   - Stimulus: the scenario 1 data with pix_valid toggled 1,0,1,0,....
   - Required: identical gray_out values and flags. Each gray_valid exactly 2 cycles after its triggering beat.
4. Resync:
   - Stimulus: sof issued mid-row1 at x=2, then a full frame of value 50.
   - Required: no output from the aborted quad; next 4 outputs are 50 with correct eol/eof.
5. Reset mid-operation:
   - Stimulus: assert rst_n=0 for 3 cycles one cycle after an odd-odd beat.
   - Required: gray_valid stays 0 (pending output dropped) and all outputs are 0. A following sof frame produces correct results.
6. Wrap:
   - Stimulus: two consecutive frames with sof only on the first; frame 2 value 200.
   - Required: 8 total outputs, last 4 equal to 200. gray_eof on the 4th and 8th pulses.
